// File: rtl/hd_loader_pkg.sv
// Shared state encoding, strobe codes and default block size for the HD-to-instruction-memory loader.
package hd_loader_pkg;

  localparam int unsigned DEF_TAM_BLOCO = 200;

  localparam logic [1:0] STROBE_IDLE = 2'b00;
  localparam logic [1:0] SAVE_WORD   = 2'b01;
  localparam logic [1:0] FIM_OK      = 2'b01;
  localparam logic [1:0] FIM_REJ     = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ_HDR,
    ST_WAIT_HDR,
    ST_REQ_WORD,
    ST_WAIT_WORD,
    ST_PUSH,
    ST_REQ_CHK,
    ST_WAIT_CHK,
    ST_END,
    ST_ERR
  } state_e;

endpackage

// File: rtl/hd_addr_gen.sv
// HD word address generator: captured block base (slot * block size) plus a word offset counter.
module hd_addr_gen
  import hd_loader_pkg::*;
#(
  parameter int unsigned TAM_BLOCO = DEF_TAM_BLOCO,
  parameter int unsigned HD_ADDR_W = 12,
  parameter int unsigned PROG_W    = 4,
  parameter int unsigned CNT_W     = $clog2(TAM_BLOCO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_base,
  input  logic [PROG_W-1:0]    prog_index,
  input  logic                 clr_off,
  input  logic                 set_off,
  input  logic                 inc_off,
  input  logic [CNT_W-1:0]     len,
  output logic [HD_ADDR_W-1:0] hd_addr,
  output logic                 last
);

  logic [HD_ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]     off_q, off_d;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    base_d = base_q;
    off_d  = off_q;
    if (load_base) begin
      base_d = HD_ADDR_W'(32'(prog_index) * TAM_BLOCO);
    end
    if (clr_off) begin
      off_d = '0;
    end else if (set_off) begin
      off_d = CNT_W'(1);
    end else if (inc_off) begin
      off_d = off_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      off_q  <= '0;
    end else begin
      base_q <= base_d;
      off_q  <= off_d;
    end
  end

  assign hd_addr = base_q + HD_ADDR_W'(off_q);
  assign last    = (off_q == len);

endmodule

// File: rtl/hd_instr_loader.sv
// Reads one program block (length header + instructions) from the HD and pushes each word to instruction memory.
// Optional macro HD_LOADER_CHECKSUM_EN: block carries a trailing XOR checksum word that must match.
module hd_instr_loader
  import hd_loader_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned TAM_BLOCO = DEF_TAM_BLOCO,
  parameter int unsigned HD_ADDR_W = 12,
  parameter int unsigned PROG_W    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PROG_W-1:0]    progIndex,
  output logic [HD_ADDR_W-1:0] hdAddr,
  output logic                 hdRead,
  input  logic [WORD_W-1:0]    hdData,
  input  logic                 hdValid,
  output logic [WORD_W-1:0]    entradaDeInstrucao,
  output logic [1:0]           controleSalvaInstrucao,
  output logic [1:0]           ControleFimDeLeitura,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned CNT_W = $clog2(TAM_BLOCO);
`ifdef HD_LOADER_CHECKSUM_EN
  localparam int unsigned LIMIT = TAM_BLOCO - 2;
`else
  localparam int unsigned LIMIT = TAM_BLOCO - 1;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              error_q, error_d;
  logic              load_base, clr_off, set_off, inc_off, last;
  logic              hdr_bad;
`ifdef HD_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;
`endif

  hd_addr_gen #(
    .TAM_BLOCO (TAM_BLOCO),
    .HD_ADDR_W (HD_ADDR_W),
    .PROG_W    (PROG_W),
    .CNT_W     (CNT_W)
  ) u_addr_gen (
    .clk        (clock),
    .rst_n      (reset),
    .load_base  (load_base),
    .prog_index (progIndex),
    .clr_off    (clr_off),
    .set_off    (set_off),
    .inc_off    (inc_off),
    .len        (len_q),
    .hd_addr    (hdAddr),
    .last       (last)
  );

  // Any header bit above the counter width makes the length unrepresentable, hence bad.
  assign hdr_bad = (hdData[WORD_W-1:CNT_W] != '0)
                || (hdData[CNT_W-1:0] == '0)
                || (32'(hdData[CNT_W-1:0]) > LIMIT);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    data_d    = data_q;
    error_d   = error_q;
    load_base = 1'b0;
    clr_off   = 1'b0;
    set_off   = 1'b0;
    inc_off   = 1'b0;
`ifdef HD_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_base = 1'b1;
          clr_off   = 1'b1;
          error_d   = 1'b0;
`ifdef HD_LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
          state_d   = ST_REQ_HDR;
        end
      end
      ST_REQ_HDR: state_d = ST_WAIT_HDR;
      ST_WAIT_HDR: begin
        if (hdValid) begin
          if (hdr_bad) begin
            error_d = 1'b1;
            state_d = ST_ERR;
          end else begin
            len_d   = hdData[CNT_W-1:0];
            set_off = 1'b1;
            state_d = ST_REQ_WORD;
          end
        end
      end
      ST_REQ_WORD: state_d = ST_WAIT_WORD;
      ST_WAIT_WORD: begin
        if (hdValid) begin
          data_d  = hdData;
`ifdef HD_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ hdData;
`endif
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (last) begin
`ifdef HD_LOADER_CHECKSUM_EN
          inc_off = 1'b1;
          state_d = ST_REQ_CHK;
`else
          state_d = ST_END;
`endif
        end else begin
          inc_off = 1'b1;
          state_d = ST_REQ_WORD;
        end
      end
`ifdef HD_LOADER_CHECKSUM_EN
      ST_REQ_CHK: state_d = ST_WAIT_CHK;
      ST_WAIT_CHK: begin
        if (hdValid) begin
          if (hdData == csum_q) begin
            state_d = ST_END;
          end else begin
            error_d = 1'b1;
            state_d = ST_ERR;
          end
        end
      end
`endif
      ST_END:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

`ifdef HD_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // Moore decode keeps strobes mutually exclusive and stable for the memory's negedge sample.
  always_comb begin
    hdRead                 = 1'b0;
    controleSalvaInstrucao = STROBE_IDLE;
    ControleFimDeLeitura   = STROBE_IDLE;
    done                   = 1'b0;
    unique case (state_q)
      ST_REQ_HDR, ST_REQ_WORD, ST_REQ_CHK: hdRead = 1'b1;
      ST_PUSH: controleSalvaInstrucao = SAVE_WORD;
      ST_END: begin
        ControleFimDeLeitura = FIM_OK;
        done                 = 1'b1;
      end
      ST_ERR:  ControleFimDeLeitura = FIM_REJ;
      default: ;
    endcase
  end

  assign busy               = (state_q != ST_IDLE);
  assign error              = error_q;
  assign entradaDeInstrucao = data_q;

endmodule

// File: tb/tb_hd_instr_loader.sv
// Directed bench for hd_instr_loader: HD responder with configurable latency, strobe monitor, immediate-assert checks.
module tb_hd_instr_loader;

`ifdef HD_LOADER_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic        clock, reset, start, hdRead, hdValid, busy, done, error;
  logic [3:0]  progIndex;
  logic [11:0] hdAddr;
  logic [31:0] hdData, entradaDeInstrucao;
  logic [1:0]  controleSalvaInstrucao, ControleFimDeLeitura;

  logic [31:0] hd_mem [0:4095];
  logic        resp_valid, spur_valid, idle_pulse, spur_en, rand_lat;
  logic [31:0] resp_data;
  int unsigned fix_lat;
  logic [31:0] sv_q[$];
  int          ad_q[$];
  int          ovl, done_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign hdValid = resp_valid | spur_valid | idle_pulse;
  assign hdData  = (spur_valid | idle_pulse) ? 32'hDEAD_BEEF : resp_data;

  hd_instr_loader dut (
    .clock                  (clock),
    .reset                  (reset),
    .start                  (start),
    .progIndex              (progIndex),
    .hdAddr                 (hdAddr),
    .hdRead                 (hdRead),
    .hdData                 (hdData),
    .hdValid                (hdValid),
    .entradaDeInstrucao     (entradaDeInstrucao),
    .controleSalvaInstrucao (controleSalvaInstrucao),
    .ControleFimDeLeitura   (ControleFimDeLeitura),
    .busy                   (busy),
    .done                   (done),
    .error                  (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  // HD model: answers each read request after fix_lat (or random 1..5) cycles.
  initial begin
    int unsigned lat;
    logic [11:0] a;
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      @(negedge clock);
      if (hdRead === 1'b1) begin
        lat = rand_lat ? $urandom_range(5, 1) : fix_lat;
        a   = hdAddr;
        repeat (lat) @(posedge clock);
        #1 resp_valid = 1'b1;
        resp_data = hd_mem[a];
        @(posedge clock);
        #1 resp_valid = 1'b0;
        resp_data = '0;
      end
    end
  end

  // Spurious valid pulses aimed at REQ and PUSH cycles, where the loader must not listen.
  initial begin
    spur_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (spur_en && (hdRead === 1'b1 || controleSalvaInstrucao != 2'b00)) begin
        spur_valid = 1'b1;
        @(posedge clock);
        #1 spur_valid = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (controleSalvaInstrucao != 2'b00) sv_q.push_back(entradaDeInstrucao);
    if (hdRead === 1'b1) ad_q.push_back(int'(hdAddr));
    if (hdRead === 1'b1 && controleSalvaInstrucao != 2'b00) ovl++;
    if (controleSalvaInstrucao != 2'b00 && ControleFimDeLeitura != 2'b00) ovl++;
    if (controleSalvaInstrucao != 2'b00 && controleSalvaInstrucao != 2'b01) ovl++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_block(input int base, input int n, input logic [31:0] seed);
    logic [31:0] x;
    x = '0;
    hd_mem[base] = 32'(n);
    for (int i = 1; i <= n; i++) begin
      hd_mem[base + i] = seed + 32'(i) * 32'h0101_0001;
      x ^= hd_mem[base + i];
    end
    hd_mem[base + n + 1] = x;
  endtask

  // Pulses start (called #1 after a posedge) and runs until a FIM strobe or the cycle budget expires.
  task automatic do_load(input logic [3:0] slot, input bit dbl_start, output int cyc,
                         output logic [1:0] fim_v, output logic done_v, output logic err_v,
                         output logic err_c1);
    cyc = 0; fim_v = '0; done_v = 1'b0; err_v = 1'b0; err_c1 = 1'bx;
    sv_q.delete(); ad_q.delete(); ovl = 0; done_cnt = 0;
    start = 1'b1;
    progIndex = slot;
    for (int i = 0; i < 5000; i++) begin
      step();
      start = 1'b0;
      cyc++;
      if (cyc == 1) err_c1 = error;
      if (dbl_start && cyc == 4) begin
        start = 1'b1;
        progIndex = 4'd7;
      end
      if (ControleFimDeLeitura != 2'b00) begin
        fim_v = ControleFimDeLeitura; done_v = done; err_v = error;
        break;
      end
    end
  endtask

  initial begin
    int cyc, mism;
    logic [1:0] fim_v;
    logic done_v, err_v, err_c1, found;
    logic [31:0] wa, wb, wc;

    reset = 1'b0; start = 1'b0; progIndex = '0;
    fix_lat = 1; rand_lat = 1'b0; spur_en = 1'b0; idle_pulse = 1'b0;
    ovl = 0; done_cnt = 0;
    for (int i = 0; i < 4096; i++) hd_mem[i] = '0;
    repeat (3) step();

    check("rst_busy",  32'(busy), 0);
    check("rst_hdrd",  32'(hdRead), 0);
    check("rst_addr",  32'(hdAddr), 0);
    check("rst_save",  32'(controleSalvaInstrucao), 0);
    check("rst_fim",   32'(ControleFimDeLeitura), 0);
    check("rst_flags", {29'd0, done, error, 1'b0}, 0);
    check("rst_data",  entradaDeInstrucao, 0);
    reset = 1'b1;
    step();

    // Slot 0, N=3, latency 1.
    wa = 32'h1111_AAAA; wb = 32'h2222_BBBB; wc = 32'h3333_CCCC;
    hd_mem[0] = 3; hd_mem[1] = wa; hd_mem[2] = wb; hd_mem[3] = wc; hd_mem[4] = wa ^ wb ^ wc;
    do_load(4'd0, 1'b0, cyc, fim_v, done_v, err_v, err_c1);
    check("t1_cycles", 32'(cyc), 32'(12 + 2 * CHK));
    check("t1_fim",    32'(fim_v), 32'h1);
    check("t1_done",   32'(done_v), 1);
    check("t1_err",    32'(err_v), 0);
    step();
    check("t1_busy_after", 32'(busy), 0);
    check("t1_fim_1cyc",   32'(ControleFimDeLeitura), 0);
    check("t1_done_cnt",   32'(done_cnt), 1);
    check("t1_nsave",      32'(sv_q.size()), 3);
    check("t1_w0", sv_q[0], wa);
    check("t1_w1", sv_q[1], wb);
    check("t1_w2", sv_q[2], wc);
    check("t1_naddr", 32'(ad_q.size()), 32'(4 + CHK));
    for (int i = 0; i < 4; i++) check("t1_addr", 32'(ad_q[i]), 32'(i));
    check("t1_overlap", 32'(ovl), 0);

    // Slot 2, longest legal block, random latency.
    rand_lat = 1'b1;
    load_block(400, 199 - CHK, 32'h5000_0000);
    do_load(4'd2, 1'b0, cyc, fim_v, done_v, err_v, err_c1);
    check("t2_fim",  32'(fim_v), 32'h1);
    check("t2_done", 32'(done_v), 1);
    step();
    check("t2_nsave", 32'(sv_q.size()), 32'(199 - CHK));
    mism = 0;
    for (int i = 0; i < sv_q.size(); i++) if (sv_q[i] !== hd_mem[401 + i]) mism++;
    check("t2_data", 32'(mism), 0);
    check("t2_addr_first", 32'(ad_q[0]), 400);
    check("t2_addr_last",  32'(ad_q[199 - CHK]), 32'(599 - CHK));
    check("t2_naddr",      32'(ad_q.size()), 32'(200));
    check("t2_overlap",    32'(ovl), 0);
    rand_lat = 1'b0;

    // Slot 1, bad headers: zero, one past the limit, upper bit set.
    hd_mem[200] = 0;
    do_load(4'd1, 1'b0, cyc, fim_v, done_v, err_v, err_c1);
    check("t3a_fim",    32'(fim_v), 32'h2);
    check("t3a_cycles", 32'(cyc), 3);
    check("t3a_done",   32'(done_v), 0);
    check("t3a_err",    32'(err_v), 1);
    step();
    check("t3a_fim_1cyc", 32'(ControleFimDeLeitura), 0);
    check("t3a_busy",     32'(busy), 0);
    repeat (4) step();
    check("t3a_sticky", 32'(error), 1);
    check("t3a_nsave",  32'(sv_q.size()), 0);
    hd_mem[200] = 200;
    do_load(4'd1, 1'b0, cyc, fim_v, done_v, err_v, err_c1);
    check("t3b_err_clr", 32'(err_c1), 0);
    check("t3b_fim",     32'(fim_v), 32'h2);
    check("t3b_err",     32'(err_v), 1);
    step();
    check("t3b_nsave", 32'(sv_q.size()), 0);
    hd_mem[200] = 32'h0001_0003;
    do_load(4'd1, 1'b0, cyc, fim_v, done_v, err_v, err_c1);
    check("t3c_fim", 32'(fim_v), 32'h2);
    step();
    check("t3c_nsave", 32'(sv_q.size()), 0);

    // Slot 3 with a second start and spurious valids during the load.
    load_block(600, 5, 32'h7000_0000);
    spur_en = 1'b1;
    do_load(4'd3, 1'b1, cyc, fim_v, done_v, err_v, err_c1);
    check("t4_fim", 32'(fim_v), 32'h1);
    check("t4_err", 32'(err_v), 0);
    step();
    spur_en = 1'b0;
    check("t4_nsave", 32'(sv_q.size()), 5);
    mism = 0;
    for (int i = 0; i < sv_q.size(); i++) if (sv_q[i] !== hd_mem[601 + i]) mism++;
    check("t4_data", 32'(mism), 0);
    check("t4_addr_first", 32'(ad_q[0]), 600);
    check("t4_addr_last",  32'(ad_q[5]), 605);
    check("t4_overlap",    32'(ovl), 0);
    idle_pulse = 1'b1;
    step();
    idle_pulse = 1'b0;
    repeat (3) step();
    check("t4_idle_busy",  32'(busy), 0);
    check("t4_idle_nsave", 32'(sv_q.size()), 5);

    // Slot 4, reset asserted during WAIT_WORD of word 5, data arrives after release.
    load_block(800, 8, 32'h9000_0000);
    fix_lat = 3;
    sv_q.delete();
    start = 1'b1; progIndex = 4'd4; found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step();
      start = 1'b0;
      if (hdRead === 1'b1 && hdAddr == 12'd805) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_reached_w5", 32'(found), 1);
    step();
    #2 reset = 1'b0;
    #1;
    check("t5_busy",  32'(busy), 0);
    check("t5_addr",  32'(hdAddr), 0);
    check("t5_data",  entradaDeInstrucao, 0);
    check("t5_strb",  {28'd0, controleSalvaInstrucao, ControleFimDeLeitura}, 0);
    check("t5_flags", {29'd0, hdRead, done, error}, 0);
    step();
    reset = 1'b1;
    check("t5_nsave_before", 32'(sv_q.size()), 4);
    repeat (10) step();
    check("t5_nsave_after", 32'(sv_q.size()), 4);
    check("t5_idle", 32'(busy), 0);
    fix_lat = 1;

    // Slot 5, N=2 with a correct checksum word, then a wrong one.
    hd_mem[1000] = 2; hd_mem[1001] = 32'h1; hd_mem[1002] = 32'h3; hd_mem[1003] = 32'h2;
    do_load(4'd5, 1'b0, cyc, fim_v, done_v, err_v, err_c1);
    check("t6_fim", 32'(fim_v), 32'h1);
    step();
    check("t6_nsave", 32'(sv_q.size()), 2);
    check("t6_w0", sv_q[0], 32'h1);
    check("t6_w1", sv_q[1], 32'h3);
`ifdef HD_LOADER_CHECKSUM_EN
    hd_mem[1003] = 32'h7;
    do_load(4'd5, 1'b0, cyc, fim_v, done_v, err_v, err_c1);
    check("t6b_fim",  32'(fim_v), 32'h2);
    check("t6b_err",  32'(err_v), 1);
    check("t6b_done", 32'(done_v), 0);
    step();
    check("t6b_nsave", 32'(sv_q.size()), 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
